// File: rtl/nerp_demo_top.sv
// 640x480 VGA "flappy" demo: a bird tracks the gap in a scrolling pipe, and the pipe-pass
// score is shown as 4 BCD digits on a multiplexed active-low 7-segment display.
`timescale 1ns/1ps
module nerp_demo_top #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned H_PULSE = 96,
    parameter int unsigned V_PULSE = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic       clk,
    input  logic       clr,
    output logic       dclk,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [2:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PW       = 10'(H_PULSE);
    localparam logic [9:0] V_PW       = 10'(V_PULSE);
    localparam logic [9:0] H_BP       = 10'(HBP);
    localparam logic [9:0] H_FP       = 10'(HFP);
    localparam logic [9:0] V_BP       = 10'(VBP);
    localparam logic [9:0] V_FP       = 10'(VFP);
    localparam logic [9:0] PIPE_START = 10'd640;
    localparam logic [9:0] BIRD_START = 10'd232;

    logic [1:0]  div_q, div_d;
    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic        hsync_q, vsync_q;
    logic [8:0]  rgb_q, rgb_d;
    logic [17:0] scan_q;
    logic [9:0]  pipe_x_q, pipe_x_d;
    logic [1:0]  gap_idx_q, gap_idx_d;
    logic [9:0]  bird_y_q, bird_y_d;
    logic [15:0] score_q, score_d, score_inc;
    logic        pix_tick, frame_tick, carry;
    logic [9:0]  gap_top, bird_target, px, py;
    logic        in_win, bird_hit, pipe_hit;
    logic [3:0]  digit;

    assign pix_tick   = (div_q == 2'd3);
    assign frame_tick = pix_tick && (hc_q == H_MAX) && (vc_q == V_MAX);

    always_comb begin
        div_d = div_q + 2'd1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (pix_tick) begin
            if (hc_q == H_MAX) begin
                hc_d = '0;
                vc_d = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_comb begin
        gap_top = 10'd120;
        case (gap_idx_q)
            2'd0: gap_top = 10'd120;
            2'd1: gap_top = 10'd200;
            2'd2: gap_top = 10'd80;
            2'd3: gap_top = 10'd260;
            default: gap_top = 10'd120;
        endcase
    end

    // Ripple BCD increment; a digit only rolls when every lower digit was 9.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign bird_target = gap_top + 10'd62;

    always_comb begin
        pipe_x_d  = pipe_x_q;
        gap_idx_d = gap_idx_q;
        bird_y_d  = bird_y_q;
        score_d   = score_q;
        if (frame_tick) begin
            if (pipe_x_q <= 10'd2) begin
                pipe_x_d  = PIPE_START;
                gap_idx_d = gap_idx_q + 2'd1;
                score_d   = score_inc;
            end else begin
                pipe_x_d = pipe_x_q - 10'd2;
            end
            if (bird_y_q < bird_target) begin
                bird_y_d = bird_y_q + 10'd1;
            end else if (bird_y_q > bird_target) begin
                bird_y_d = bird_y_q - 10'd1;
            end
        end
    end

    always_comb begin
        px       = hc_q - H_BP;
        py       = vc_q - V_BP;
        in_win   = (hc_q >= H_BP) && (hc_q < H_FP) && (vc_q >= V_BP) && (vc_q < V_FP);
        bird_hit = (px >= 10'd100) && (px < 10'd116) &&
                   (py >= bird_y_q) && (py < bird_y_q + 10'd16);
        pipe_hit = ({1'b0, pipe_x_q} <= {1'b0, px} + 11'd40) && (px < pipe_x_q) &&
                   ((py < gap_top) || (py >= gap_top + 10'd140));
        rgb_d = '0;
        if (in_win) begin
            if (bird_hit) begin
                rgb_d = 9'b111_111_000;
            end else if (pipe_hit) begin
                rgb_d = 9'b000_111_000;
            end else begin
                rgb_d = 9'b000_000_111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q     <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= '0;
            scan_q    <= '0;
            pipe_x_q  <= PIPE_START;
            gap_idx_q <= '0;
            bird_y_q  <= BIRD_START;
            score_q   <= '0;
        end else begin
            div_q     <= div_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hsync_q   <= (hc_q >= H_PW);
            vsync_q   <= (vc_q >= V_PW);
            rgb_q     <= rgb_d;
            scan_q    <= scan_q + 18'd1;
            pipe_x_q  <= pipe_x_d;
            gap_idx_q <= gap_idx_d;
            bird_y_q  <= bird_y_d;
            score_q   <= score_d;
        end
    end

    always_comb begin
        an    = 4'b1110;
        digit = score_q[3:0];
        case (scan_q[17:16])
            2'd0: begin an = 4'b1110; digit = score_q[3:0];   end
            2'd1: begin an = 4'b1101; digit = score_q[7:4];   end
            2'd2: begin an = 4'b1011; digit = score_q[11:8];  end
            2'd3: begin an = 4'b0111; digit = score_q[15:12]; end
            default: begin an = 4'b1111; digit = 4'd0; end
        endcase
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    assign dclk               = div_q[1];
    assign {red, green, blue} = rgb_q;
    assign hsync              = hsync_q;
    assign vsync              = vsync_q;
    assign dp                 = 1'b1;
endmodule

// File: tb/tb_nerp_demo_top.sv
// Directed bench for nerp_demo_top: expectations are queued when stimulus is applied and
// popped when the corresponding output is sampled.
`timescale 1ns/1ps
module tb_nerp_demo_top;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       dclk;
    logic [2:0] red, green, blue;
    logic       hsync, vsync;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    nerp_demo_top dut (
        .clk   (clk),
        .clr   (clr),
        .dclk  (dclk),
        .red   (red),
        .green (green),
        .blue  (blue),
        .hsync (hsync),
        .vsync (vsync),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    task automatic expect_v(input string tag, input logic [31:0] e);
        exp_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t it;
        it = sb.pop_front();
        total++;
        assert (obs === it.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
        end
    endtask

    task automatic do_reset(input int unsigned cycles);
        @(negedge clk);
        clr = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_pos(input logic [9:0] v, input logic [9:0] h,
                            input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (dut.vc_q == v && dut.hc_q == h) ok = 1'b1;
        end
    endtask

    task automatic frame_ticks(input int unsigned n);
        @(negedge clk);
        force dut.frame_tick = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        release dut.frame_tick;
    endtask

    task automatic pixel_check(input string tag, input logic [9:0] v, input logic [9:0] h,
                               input logic [8:0] exp_rgb);
        bit ok;
        expect_v({tag, "_reach"}, 32'd1);
        wait_pos(v, h, 4000, ok);
        check(32'(ok));
        @(negedge clk);
        expect_v(tag, 32'(exp_rgb));
        check(32'({red, green, blue}));
    endtask

    logic [9:0]  vc_force;
    logic [17:0] scan_val;

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned dclk_r1 = 0, dclk_r2 = 0, hs_f1 = 0, hs_f2 = 0, hs_r1 = 0;
        logic prev_d, prev_h;
        bit ok;

        // Reset held for 100 ns, values sampled while clr is still high.
        clr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_v("rst_hsync", 32'd1);     check(32'(hsync));
        expect_v("rst_vsync", 32'd1);     check(32'(vsync));
        expect_v("rst_rgb",   32'd0);     check(32'({red, green, blue}));
        expect_v("rst_dclk",  32'd0);     check(32'(dclk));
        expect_v("rst_an",    32'hE);     check(32'(an));
        expect_v("rst_seg",   32'h40);    check(32'(seg));
        expect_v("rst_dp",    32'd1);     check(32'(dp));
        clr = 1'b0;

        prev_d = dclk;
        prev_h = hsync;
        for (int unsigned i = 1; i <= 3300; i++) begin
            @(posedge clk);
            #1;
            if (dclk && !prev_d) begin
                if (dclk_r1 == 0) dclk_r1 = i;
                else if (dclk_r2 == 0) dclk_r2 = i;
            end
            if (!hsync && prev_h) begin
                if (hs_f1 == 0) hs_f1 = i;
                else if (hs_f2 == 0) hs_f2 = i;
            end
            if (hsync && !prev_h && hs_r1 == 0) hs_r1 = i;
            prev_d = dclk;
            prev_h = hsync;
        end
        expect_v("dclk_first_rise_ns", 32'd20);    check(32'(dclk_r1 * 10));
        expect_v("dclk_period_ns",     32'd40);    check(32'((dclk_r2 - dclk_r1) * 10));
        expect_v("hsync_fall_in_line", 32'd1);     check(32'(hs_f1 >= 1 && hs_f1 <= 3200));
        expect_v("hsync_low_ns",       32'd3840);  check(32'((hs_r1 - hs_f1) * 10));
        expect_v("hsync_period_ns",    32'd32000); check(32'((hs_f2 - hs_f1) * 10));
        expect_v("vsync_low_line0",    32'd0);     check(32'(vsync));

        // Line vc=271 in the reset frame: bird at py 232..247, pipe off-screen.
        do_reset(10);
        vc_force = 10'd271;
        force dut.vc_q = vc_force;
        pixel_check("rgb_hblank", 10'd271, 10'd50,  9'b000_000_000);
        pixel_check("rgb_bird",   10'd271, 10'd251, 9'b111_111_000);
        pixel_check("rgb_sky",    10'd271, 10'd444, 9'b000_000_111);
        @(negedge clk);
        release dut.vc_q;

        // 100 frames: pipe_x=440, gap top 120, bird settled exactly at 182.
        do_reset(4);
        frame_ticks(100);
        vc_force = 10'd60;
        force dut.vc_q = vc_force;
        pixel_check("rgb_left_of_pipe", 10'd60, 10'd444, 9'b000_000_111);
        pixel_check("rgb_pipe",         10'd60, 10'd564, 9'b000_111_000);
        @(negedge clk);
        vc_force = 10'd212;
        pixel_check("rgb_above_bird",   10'd212, 10'd251, 9'b000_000_111);
        @(negedge clk);
        vc_force = 10'd213;
        pixel_check("rgb_bird_top",     10'd213, 10'd251, 9'b111_111_000);
        @(negedge clk);
        release dut.vc_q;

        // 320 frames: exactly one pipe wrap.
        do_reset(4);
        frame_ticks(320);
        #1;
        expect_v("wrap_pipe_x",  32'd640);   check(32'(dut.pipe_x_q));
        expect_v("wrap_gap_top", 32'd200);   check(32'(dut.gap_top));
        expect_v("wrap_score",   32'h0001);  check(32'(dut.score_q));
        expect_v("wrap_an",      32'hE);     check(32'(an));
        expect_v("wrap_seg",     32'h79);    check(32'(seg));

        // Mid-line reset on line 1 at hc=400.
        expect_v("midrst_reach", 32'd1);
        wait_pos(10'd1, 10'd400, 8000, ok);
        check(32'(ok));
        clr = 1'b1;
        @(posedge clk);
        #1;
        expect_v("midrst_hc",    32'd0);     check(32'(dut.hc_q));
        expect_v("midrst_vc",    32'd0);     check(32'(dut.vc_q));
        expect_v("midrst_hsync", 32'd1);     check(32'(hsync));
        expect_v("midrst_score", 32'h0000);  check(32'(dut.score_q));
        expect_v("midrst_seg",   32'h40);    check(32'(seg));
        clr = 1'b0;

        // Score 9999 preloaded just before a pipe wrap.
        do_reset(4);
        frame_ticks(319);
        force dut.score_q = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        release dut.score_q;
        #1;
        expect_v("pre_an",  32'hE);  check(32'(an));
        expect_v("pre_seg", 32'h10); check(32'(seg));
        frame_ticks(1);
        #1;
        expect_v("rollover_score",  32'h0000); check(32'(dut.score_q));
        expect_v("rollover_pipe_x", 32'd640);  check(32'(dut.pipe_x_q));
        for (int unsigned d = 0; d < 4; d++) begin
            logic [3:0] an_exp;
            an_exp   = 4'b1111 & ~(4'b0001 << d);
            scan_val = {2'(d), 16'h0000};
            @(negedge clk);
            force dut.scan_q = scan_val;
            #1;
            expect_v($sformatf("digit%0d_an", d), 32'(an_exp)); check(32'(an));
            expect_v($sformatf("digit%0d_seg", d), 32'h40);     check(32'(seg));
            release dut.scan_q;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nerp_demo_top.md
NERP_DEMO_TOP -- requirements
Module: nerp_demo_top

Interface
REQ-001 SHALL have parameters: H_TOTAL 800 (dclk per line); V_TOTAL 521 (lines per frame); H_PULSE 96; V_PULSE 2; HBP 144; HFP 784; VBP 31; VFP 511 (active-window bounds, counter units).
REQ-002 SHALL have port clk, input, 1, 100 MHz system clock; the only clock in the block.
REQ-003 SHALL have port clr, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port dclk, output, 1, 25 MHz pixel rate, clk/4, derived from a 2-bit divider.
REQ-005 SHALL have ports red, green and blue, output, 3 bits each, VGA colour.
REQ-006 SHALL have ports hsync and vsync, output, 1 each, active-low sync.
REQ-007 SHALL have ports seg[6:0], an[3:0] and dp, outputs, active-low 7-seg.
- seg[0]=a … seg[6]=g.

Function
REQ-008 SHALL use a 2-bit counter on clk; dclk = counter[1]; pixel tick = counter==3, one clk wide.
REQ-009 SHALL advance hc 0..799 per pixel tick; vc 0..520 SHALL increment when hc wraps to 0, and vc SHALL wrap at 520.
REQ-010 SHALL drive hsync=0 iff hc<96 and vsync=0 iff vc<2, both registered.
REQ-011 SHALL treat the active window as 144≤hc<784 and 31≤vc<511.
- px=hc-144 (0..639), py=vc-31 (0..479).
- Outside the window, red/green/blue SHALL be 0.
REQ-012 SHALL raise a frame tick for one clk on the pixel tick where hc=799 and vc=520.
- All game state SHALL update only on the frame tick.
REQ-013 SHALL implement a pipe: 10-bit pipe_x, reset 640, width 40.
- Each frame: if pipe_x≤2, pipe_x←640, gap index increments mod 4, score increments; else pipe_x←pipe_x-2.
REQ-014 SHALL select gap top from the gap index via table {120,200,80,260}; gap height 140.
REQ-015 SHALL implement a bird: 16×16 square at px 100..115, py bird_y..bird_y+15, bird_y reset 232.
- Each frame bird_y SHALL move 1 toward (gap_top+62), saturating, with no overshoot.
REQ-016 SHALL apply pixel colour priority: bird {7,7,0}; else pipe {0,7,0}; else sky {0,0,7}.
- Pipe pixels: pipe_x≤px+40 and px<pipe_x, with py<gap_top or py≥gap_top+140.
REQ-017 SHALL keep score as 4 BCD digits, each 0..9, with decimal carry; 9999+1 SHALL wrap to 0000.
REQ-018 SHALL scan the display from an 18-bit clk counter; bits[17:16] select digit 0..3.
- an SHALL be one-hot low: 1110 is the ones digit … 0111 the thousands digit.
- seg SHALL carry the standard active-low decimal pattern, e.g. 0=1000000, 1=1111001, 8=0000000.
REQ-019 SHALL drive dp=1 constantly.

Reset
REQ-020 SHALL, while clr=1 at a clk edge, clear the divider, hc, vc and the scan counter.
- Reset values: pipe_x=640, gap index 0, bird_y=232, score 0000.
- Reset outputs: hsync=1, vsync=1, rgb=0, dclk=0, an=1110, seg=1000000, dp=1.
REQ-021 SHALL resume at a mid-operation reset from the reset state on the next clk after clr falls, with no partial frame carried over.

Verification
REQ-022 SHALL pass: clr high 100 ns, then low -> the REQ-020 values are held during reset; first dclk rise 20 ns after release; dclk period 40 ns.
REQ-023 SHALL pass: run 1 ms -> hsync low 3.84 µs every 32.0 µs; first hsync falling edge within one line of reset release.
REQ-024 SHALL pass: at line vc=271, px=107 (bird) -> rgb {7,7,0}; px=300 -> rgb {0,0,7}; hc<144 -> rgb 0.
REQ-025 SHALL pass: force the frame tick 320 times after reset -> pipe wraps once, score=0001, an=1110 segment pattern 1111001, gap top 200.
REQ-026 SHALL pass: preload score 9999 plus one pipe wrap -> score 0000, every digit shows 1000000.
REQ-027 SHALL pass: assert clr mid-line at hc=400 -> next clk hc=0, vc=0, hsync=1, score 0000.
